// File: rtl/pulse_train_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : pulse_train_arbiter_if
// Purpose  : Request/config inputs and shared pulse-train outputs of the
//            two-requester pulse-train arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface pulse_train_arbiter_if #(
  parameter int CW = 8
);
  logic          req0;
  logic [CW-1:0] hi0;
  logic [CW-1:0] lo0;
  logic [CW-1:0] cnt0;
  logic          req1;
  logic [CW-1:0] hi1;
  logic [CW-1:0] lo1;
  logic [CW-1:0] cnt1;
  logic [1:0]    grant;
  logic          signal;
  logic          busy;
  logic          done0;
  logic          done1;

  // Requester side: drives requests and configuration, observes the train
  modport master (
    output req0, hi0, lo0, cnt0, req1, hi1, lo1, cnt1,
    input  grant, signal, busy, done0, done1
  );

  // Arbiter side
  modport slave (
    input  req0, hi0, lo0, cnt0, req1, hi1, lo1, cnt1,
    output grant, signal, busy, done0, done1
  );
endinterface
`default_nettype wire

// File: rtl/pulse_train_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pulse_train_arbiter
// Purpose  : Round-robin sharing of one registered pulse-train output between
//            two requesters; each supplies high width, low width and count.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_train_arbiter #(
  parameter int CW = 8
) (
  input  wire logic            clock,
  input  wire logic            reset,
  pulse_train_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t        state;
  logic          last;      // index of the most recent winner
  logic [CW-1:0] hi_len;    // latched high width (0 promoted to 1)
  logic [CW-1:0] lo_len;    // latched low width (0 promoted to 1)
  logic [CW-1:0] rem;       // pulses still to finish, including current one
  logic [CW-1:0] tmr;       // cycles left in the current phase
  logic [1:0]    owner;
  logic          pulse;
  logic          busy_q;
  logic          done0_q;
  logic          done1_q;

  logic          pick1;
  logic          any_req;
  logic [CW-1:0] sel_hi;
  logic [CW-1:0] sel_lo;
  logic [CW-1:0] sel_cnt;

  // Winner selection: a lone requester wins; on contention the one that
  // did not win last time is served.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    pick1   = bus.req1 & (~bus.req0 | ~last);
    sel_hi  = pick1 ? bus.hi1  : bus.hi0;
    sel_lo  = pick1 ? bus.lo1  : bus.lo0;
    sel_cnt = pick1 ? bus.cnt1 : bus.cnt0;
    if (sel_hi == '0) sel_hi = CW'(1);
    if (sel_lo == '0) sel_lo = CW'(1);
  end

  // Arbitration and train-generation state machine with registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      last    <= 1'b1;
      hi_len  <= '0;
      lo_len  <= '0;
      rem     <= '0;
      tmr     <= '0;
      owner   <= 2'b00;
      pulse   <= 1'b0;
      busy_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          if (any_req) begin
            last   <= pick1;
            owner  <= pick1 ? 2'b10 : 2'b01;
            busy_q <= 1'b1;
            hi_len <= sel_hi;
            lo_len <= sel_lo;
            rem    <= sel_cnt;
            if (sel_cnt != '0) begin
              state <= HIGH;
              pulse <= 1'b1;
              tmr   <= sel_hi;
            end else begin
              // Zero-count train holds the grant for two cycles, no pulses
              state <= FINISH;
              pulse <= 1'b0;
              tmr   <= CW'(2);
            end
          end
        end
        HIGH: begin
          if (tmr == CW'(1)) begin
            state <= LOW;
            pulse <= 1'b0;
            tmr   <= lo_len;
          end else begin
            tmr <= tmr - CW'(1);
          end
        end
        LOW: begin
          if (tmr == CW'(1)) begin
            if (rem == CW'(1)) begin
              state   <= IDLE;
              owner   <= 2'b00;
              busy_q  <= 1'b0;
              done0_q <= owner[0];
              done1_q <= owner[1];
            end else begin
              rem   <= rem - CW'(1);
              state <= HIGH;
              pulse <= 1'b1;
              tmr   <= hi_len;
            end
          end else begin
            tmr <= tmr - CW'(1);
          end
        end
        FINISH: begin
          if (tmr == CW'(1)) begin
            state   <= IDLE;
            owner   <= 2'b00;
            busy_q  <= 1'b0;
            done0_q <= owner[0];
            done1_q <= owner[1];
          end else begin
            tmr <= tmr - CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          owner  <= 2'b00;
          busy_q <= 1'b0;
          pulse  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant  = owner;
  assign bus.signal = pulse;
  assign bus.busy   = busy_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;

endmodule
`default_nettype wire
